// File: rtl/seven_seg_mux_pkg.sv
`default_nettype none
// ============================================================================
// seven_seg_pkg : active-low glyph table, hex decoder and load-content record
//                 shared by the seven_seg_mux display driver.
// Revision      : 1.0
// ============================================================================
package seven_seg_pkg;

  localparam int MAX_DIGITS = 8;

  // {ca,cb,cc,cd,ce,cf,cg}, 0 = segment lit
  localparam logic [6:0] ZERO   = 7'h01;
  localparam logic [6:0] ONE    = 7'h4F;
  localparam logic [6:0] TWO    = 7'h12;
  localparam logic [6:0] THREE  = 7'h06;
  localparam logic [6:0] FOUR   = 7'h4C;
  localparam logic [6:0] FIVE   = 7'h24;
  localparam logic [6:0] SIX    = 7'h20;
  localparam logic [6:0] SEVEN  = 7'h0F;
  localparam logic [6:0] EIGHT  = 7'h00;
  localparam logic [6:0] NINE   = 7'h04;
  localparam logic [6:0] CHAR_A = 7'h08;
  localparam logic [6:0] CHAR_B = 7'h60;
  localparam logic [6:0] CHAR_C = 7'h31;
  localparam logic [6:0] CHAR_D = 7'h42;
  localparam logic [6:0] CHAR_E = 7'h30;
  localparam logic [6:0] CHAR_F = 7'h38;
  localparam logic [6:0] NONE   = 7'h7F;

  typedef struct packed {
    logic [4*MAX_DIGITS-1:0] value;
    logic [MAX_DIGITS-1:0]   dots;
    logic [MAX_DIGITS-1:0]   en;
    logic                    lz;
  } disp_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = ZERO;
      4'h1:    hex_to_seg = ONE;
      4'h2:    hex_to_seg = TWO;
      4'h3:    hex_to_seg = THREE;
      4'h4:    hex_to_seg = FOUR;
      4'h5:    hex_to_seg = FIVE;
      4'h6:    hex_to_seg = SIX;
      4'h7:    hex_to_seg = SEVEN;
      4'h8:    hex_to_seg = EIGHT;
      4'h9:    hex_to_seg = NINE;
      4'hA:    hex_to_seg = CHAR_A;
      4'hB:    hex_to_seg = CHAR_B;
      4'hC:    hex_to_seg = CHAR_C;
      4'hD:    hex_to_seg = CHAR_D;
      4'hE:    hex_to_seg = CHAR_E;
      default: hex_to_seg = CHAR_F;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_mux_if.sv
`default_nettype none
// ============================================================================
// seven_seg_mux_if : valid/ready load port carrying new display content.
// Revision         : 1.0
// ============================================================================
interface seven_seg_mux_if #(
  parameter int DIGITS = 8
);
  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dots;
  logic [DIGITS-1:0]     digit_en;
  logic                  lz_blank;

  modport master (output load_valid, value, dots, digit_en, lz_blank, input load_ready);
  modport slave  (input load_valid, value, dots, digit_en, lz_blank, output load_ready);
endinterface
`default_nettype wire

// File: rtl/seven_seg_mux_scan.sv
`default_nettype none
// ============================================================================
// seven_seg_scan : slot counter and digit index for the multiplexed display.
// Revision       : 1.0
// ============================================================================
module seven_seg_scan #(
  parameter int DIGITS = 8,
  parameter int STEP   = 10000,
  parameter int IDX_W  = $clog2(DIGITS),
  parameter int CNT_W  = $clog2(STEP)
) (
  input  logic             clk_100mhz,
  input  logic             nrst,
  output logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output logic             slot_last,
  output logic             frame_last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    slot_last  = (cnt_q == CNT_W'(STEP - 1));
    frame_last = slot_last && (idx_q == IDX_W'(DIGITS - 1));
    cnt_d      = slot_last ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_last) begin
      idx_d = frame_last ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt = cnt_q;
  assign idx = idx_q;

endmodule
`default_nettype wire

// File: rtl/seven_seg_mux.sv
`default_nettype none
// ============================================================================
// seven_seg_mux : time-multiplexed common-anode 7-segment driver with
//                 frame-aligned content commit. Optional: SEVEN_SEG_DIM_EN.
// Revision      : 1.0
// ============================================================================
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int STEP   = 10000,
  parameter int IDX_W  = $clog2(DIGITS),
  parameter int CNT_W  = $clog2(STEP)
) (
  input  logic              clk_100mhz,
  input  logic              nrst,
  seven_seg_mux_if.slave    load,
`ifdef SEVEN_SEG_DIM_EN
  input  logic [3:0]        brightness,
`endif
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an,
  output logic [IDX_W-1:0]  cur_digit,
  output logic              frame_tick
);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             slot_last;
  logic             frame_last;

  seven_seg_scan #(
    .DIGITS (DIGITS),
    .STEP   (STEP),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) u_scan (
    .clk_100mhz (clk_100mhz),
    .nrst       (nrst),
    .cnt        (cnt),
    .idx        (idx),
    .slot_last  (slot_last),
    .frame_last (frame_last)
  );

  disp_t               pend_data_q, pend_data_d;
  logic                pend_q, pend_d;
  logic [4*DIGITS-1:0] sh_value_q, sh_value_d;
  logic [DIGITS-1:0]   sh_dots_q, sh_dots_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [DIGITS-1:0]   commit_blank;
  logic                upper_zero;

  // Leading-zero run is tracked from the most significant digit downwards
  always_comb begin
    upper_zero   = 1'b1;
    commit_blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero      = upper_zero && (pend_data_q.value[4*k +: 4] == 4'h0) && !pend_data_q.dots[k];
      commit_blank[k] = !pend_data_q.en[k] || (pend_data_q.lz && (k != 0) && upper_zero);
    end
  end

  always_comb begin
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    sh_value_d  = sh_value_q;
    sh_dots_d   = sh_dots_q;
    sh_blank_d  = sh_blank_q;
    if (frame_last && pend_q) begin
      sh_value_d = pend_data_q.value[4*DIGITS-1:0];
      sh_dots_d  = pend_data_q.dots[DIGITS-1:0];
      sh_blank_d = commit_blank;
      pend_d     = 1'b0;
    end
    // A transfer in the commit cycle only lands in pending, never in shadow
    if (load.load_valid && !pend_q) begin
      pend_d                            = 1'b1;
      pend_data_d                       = '0;
      pend_data_d.value[4*DIGITS-1:0]   = load.value;
      pend_data_d.dots[DIGITS-1:0]      = load.dots;
      pend_data_d.en[DIGITS-1:0]        = load.digit_en;
      pend_data_d.lz                    = load.lz_blank;
    end
  end

  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      sh_value_q  <= '0;
      sh_dots_q   <= '0;
      sh_blank_q  <= '1;
    end else begin
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      sh_value_q  <= sh_value_d;
      sh_dots_q   <= sh_dots_d;
      sh_blank_q  <= sh_blank_d;
    end
  end

  if (DIGITS < MAX_DIGITS) begin : g_unused_hi
    logic unused_pend_hi;
    assign unused_pend_hi = ^{pend_data_q.value[4*MAX_DIGITS-1:4*DIGITS],
                              pend_data_q.dots[MAX_DIGITS-1:DIGITS],
                              pend_data_q.en[MAX_DIGITS-1:DIGITS]};
  end

  logic drive_on;

`ifdef SEVEN_SEG_DIM_EN
  logic [CNT_W:0] on_lim_q, on_lim_d;

  // Brightness is taken on the edge that opens a slot and held for that slot
  always_comb begin
    on_lim_d = on_lim_q;
    if (slot_last) begin
      on_lim_d = (CNT_W+1)'(((32'(brightness) + 32'd1) * 32'(STEP)) >> 4);
    end
  end

  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      on_lim_q <= (CNT_W+1)'(STEP);
    end else begin
      on_lim_q <= on_lim_d;
    end
  end

  assign drive_on = ({1'b0, cnt} < on_lim_q);
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt;
  assign drive_on   = 1'b1;
`endif

  always_comb begin
    an         = '1;
    seg        = NONE;
    dp         = 1'b1;
    cur_digit  = idx;
    frame_tick = frame_last;
    if (drive_on) begin
      an[idx] = 1'b0;
      if (!sh_blank_q[idx]) begin
        seg = hex_to_seg(sh_value_q[{idx, 2'b00} +: 4]);
        dp  = ~sh_dots_q[idx];
      end
    end
  end

  assign load.load_ready = ~pend_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_mux.sv
`default_nettype none
// ============================================================================
// tb_seven_seg_mux : directed + random load traffic checked against a
//                    cycle-count based model of the multiplexed display.
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_seven_seg_mux;

  localparam int DIGITS = 4;
  localparam int STEP   = 16;
  localparam int FRAME  = DIGITS * STEP;

  logic clk_100mhz = 1'b0;
  logic nrst       = 1'b1;
  always #5 clk_100mhz = ~clk_100mhz;

  seven_seg_mux_if #(.DIGITS(DIGITS)) ld_if ();

  logic [6:0]                seg;
  logic                      dp;
  logic [DIGITS-1:0]         an;
  logic [$clog2(DIGITS)-1:0] cur_digit;
  logic                      frame_tick;

  seven_seg_mux #(
    .DIGITS (DIGITS),
    .STEP   (STEP)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .nrst       (nrst),
    .load       (ld_if),
`ifdef SEVEN_SEG_DIM_EN
    .brightness (4'hF),
`endif
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .cur_digit  (cur_digit),
    .frame_tick (frame_tick)
  );

  logic [6:0] glyph [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  int total = 0;
  int bad   = 0;

  // Model: cycles since reset plus the content in pending and on display
  int          n;
  bit          m_pend;
  logic [15:0] p_val, s_val;
  logic [3:0]  p_dots, s_dots, p_en, s_en;
  logic        p_lz, s_lz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] val, input logic [3:0] d,
                       input logic [3:0] e, input logic l);
    ld_if.load_valid = v;
    ld_if.value      = val;
    ld_if.dots       = d;
    ld_if.digit_en   = e;
    ld_if.lz_blank   = l;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    chk("rst_an", an, 4'b1110);
    chk("rst_cur_digit", cur_digit, 0);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_load_ready", ld_if.load_ready, 1);
    chk("rst_frame_tick", frame_tick, 0);
    n = 0; m_pend = 0;
    s_val = '0; s_dots = '0; s_en = '0; s_lz = 0;
    p_val = '0; p_dots = '0; p_en = '0; p_lz = 0;
    #1;
    nrst = 1'b1;
  endtask

  task automatic cyc();
    int          k;
    bit          blank, xfer, commit;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [15:0] in_val;
    logic [3:0]  in_dots, in_en;
    logic        in_lz;
    k      = (n / STEP) % DIGITS;
    blank  = !s_en[k] || (s_lz && k != 0 && (s_val >> (4*k)) == 0 && (s_dots >> k) == 0);
    exp_an = ~(4'b0001 << k);
    exp_seg = blank ? 7'h7F : glyph[s_val[4*k +: 4]];
    exp_dp  = blank ? 1'b1 : !s_dots[k];
    chk("an", an, exp_an);
    chk("cur_digit", cur_digit, k);
    chk("frame_tick", frame_tick, (n % FRAME) == FRAME - 1);
    chk("load_ready", ld_if.load_ready, !m_pend);
    chk("seg", seg, exp_seg);
    chk("dp", dp, exp_dp);
    xfer    = ld_if.load_valid && !m_pend;
    commit  = (n % FRAME) == FRAME - 1;
    in_val  = ld_if.value;
    in_dots = ld_if.dots;
    in_en   = ld_if.digit_en;
    in_lz   = ld_if.lz_blank;
    @(posedge clk_100mhz);
    #1;
    if (commit && m_pend) begin
      s_val = p_val; s_dots = p_dots; s_en = p_en; s_lz = p_lz;
      m_pend = 0;
    end
    if (xfer) begin
      p_val = in_val; p_dots = in_dots; p_en = in_en; p_lz = in_lz;
      m_pend = 1;
    end
    n++;
  endtask

  initial begin
    drive(0, 16'h0, 4'h0, 4'h0, 0);
    #1;
    do_reset();
    repeat (2 * FRAME) cyc();

    // First load, then a competing load that must be ignored while pending
    drive(1, 16'h12AF, 4'b0100, 4'hF, 0);
    cyc();
    drive(1, 16'h5555, 4'hF, 4'hF, 1);
    repeat (10) cyc();
    drive(0, 16'h0, 4'h0, 4'h0, 0);
    repeat (2 * FRAME) cyc();

    drive(1, 16'h0030, 4'h0, 4'hF, 1);
    cyc();
    drive(0, 16'h0, 4'h0, 4'h0, 0);
    repeat (2 * FRAME) cyc();
    drive(1, 16'h0000, 4'h0, 4'hF, 1);
    cyc();
    drive(0, 16'h0, 4'h0, 4'h0, 0);
    repeat (2 * FRAME) cyc();

    // Transfer exactly in the commit cycle
    for (int g = 0; g < FRAME && (n % FRAME) != FRAME - 1; g++) cyc();
    drive(1, 16'hBEEF, 4'b1001, 4'b1011, 0);
    cyc();
    drive(0, 16'h0, 4'h0, 4'h0, 0);
    repeat (3 * FRAME) cyc();

    repeat (1500) begin
      drive(logic'($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom),
            4'($urandom), 1'($urandom));
      cyc();
    end

    // Reset mid-frame with content still pending
    drive(1, 16'h7777, 4'hF, 4'hF, 0);
    cyc();
    drive(0, 16'h0, 4'h0, 4'h0, 0);
    repeat (20) cyc();
    do_reset();
    repeat (FRAME + 8) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_mux.md
Name: seven_seg_mux

Overview:
Parametrised, time-multiplexed 7-segment display driver for DIGITS common-anode digits.
- Takes a full hex word, per-digit decimal points, per-digit enables and a leading-zero-blank mode through a valid/ready load port.
- Commits new content only at frame boundaries, so the display never tears.
- Sits between user logic (flash status/address display) and the board's ca..cg/dp/an pins.

Parameters:
DIGITS, 8, number of multiplexed digits (2..8)
STEP, 10000, clk_100mhz cycles per digit slot (≥16)
IDX_W, $clog2(DIGITS), digit index width (derived, not overridden)
CNT_W, $clog2(STEP), slot counter width (derived)

Ports:
clk_100mhz  in  1  system clock
nrst  in  1  asynchronous active-low reset
load_valid  in  1  new display content offered
load_ready  out  1  high when no update is pending
value  in  4*DIGITS  hex nibbles; nibble k shown on digit k (digit 0 rightmost)
dots  in  DIGITS  decimal point per digit, 1 = lit
digit_en  in  DIGITS  1 = digit may light, 0 = forced blank
lz_blank  in  1  suppress leading zeros
seg  out  7  {ca,cb,cc,cd,ce,cf,cg}, active low
dp  out  1  decimal point, active low
an  out  DIGITS  anode select, one-cold
cur_digit  out  IDX_W  digit currently driven
frame_tick  out  1  1-cycle pulse at each frame boundary

Behaviour:
Reset:
- cnt=0, idx=0, pending empty.
- Shadow registers cleared: value 0, dots 0, enables 0, blank mask all 1.
- Outputs: an=~1 (digit 0 selected), seg=7'h7F, dp=1, load_ready=1, frame_tick=0, cur_digit=0.

Scan:
- cnt increments each cycle; at cnt==STEP-1 it wraps to 0 and idx advances.
- idx wraps DIGITS-1 → 0.
- an[idx]=0, all other anode bits 1; cur_digit=idx.
- The slot for digit k lasts exactly STEP cycles; a frame lasts DIGITS*STEP cycles.

Load handshake:
- Transfer occurs when load_valid && load_ready.
- value/dots/digit_en/lz_blank are captured into pending; pend is set, so load_ready=0 from the next cycle.
- load_valid while load_ready=0 is ignored; the source must hold it.

Commit:
- Commit cycle: cnt==STEP-1 && idx==DIGITS-1.
- In that cycle frame_tick=1, and if pend is set, pending → shadow and pend clears.
- New content is visible from digit 0 of the next frame. Latency from transfer to first display is ≤ DIGITS*STEP+1 cycles.

Simultaneous events:
- Transfer in the commit cycle (pend previously empty) is captured into pending only. It is not bypassed to shadow and commits at the following boundary.

Blank mask:
- Computed once at commit and stored in shadow as a register.
- Digit k is blanked if digit_en[k]=0.
- Digit k is also blanked if lz_blank=1, k≠0, nibbles k..DIGITS-1 are all 0, and dots[k..DIGITS-1] are all 0.
- Digit 0 is never blanked by lz_blank.

Segments:
- Blanked digit: seg=7'h7F, dp=1.
- Otherwise seg = hex glyph of nibble idx (0-9, A, b, C, d, E, F; same glyph table as existing display blocks) and dp=~dots[idx].

Timing and mid-operation reset:
- All outputs depend only on registers; there is no input-to-output combinational path.
- Reset mid-frame returns to the reset state immediately and discards pending content.

Optional Feature:
SEVEN_SEG_DIM_EN
- Defined: adds input brightness[3:0]. Within each slot, an[idx] is driven low and seg/dp are driven only while cnt < ((brightness+1)*STEP)>>4; otherwise an is all 1s, seg=7'h7F and dp=1. brightness is sampled at the start of each slot (cnt==0).
- Undefined: no port; the anode is active for the full slot.

Decomposition:
- Package seven_seg_pkg holds:
  - the glyph localparams (ZERO..CHAR_F, NONE);
  - a function hex_to_seg(logic [3:0]) → logic [6:0];
  - typedef disp_t (packed struct: value, dots, en, lz).
- One sub-module, seven_seg_scan: the cnt/idx counter producing idx, slot_last and frame_last.

Test Plan:
- Reset, then STEP=16, DIGITS=4 → an cycles 1110, 1101, 1011, 0111, each held exactly 16 cycles; frame_tick pulses every 64 cycles.
- Load value=16'h12AF, dots=4'b0100, en=4'hF → after the next frame_tick, digits 0..3 show F, A, 2, 1; dp=0 only while an=1011.
- lz_blank=1, value=16'h0030 → digits 3 and 2 blank, digit 1 shows "3", digit 0 shows "0". With value=0 → only digit 0 shows "0".
- Assert load_valid mid-frame → load_ready falls next cycle. A second load with different data is ignored. load_ready rises the cycle after frame_tick.
- Transfer in the commit cycle → old content for one more frame, new content the frame after.
- SEVEN_SEG_DIM_EN, brightness=3, STEP=16 → an[idx] low for 4 of every 16 cycles. brightness=15 → low for all 16.
